pipe_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS core. Drives the IF/ID register controls (`hazard_stall`, `exe_stall`, `cond_exe_stall`), the PC write enable and the ID/EX flush. It covers three cases:
- load-use interlocks detected in ID;
- multi-cycle mult/div occupancy of EX, sequenced by an internal FSM;
- data-memory wait handshakes.

Taken branches and jumps resolved in EX flush the younger instructions.

---
 rtl/pipe_ctrl_if.sv | 63 ++++++
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundle between the 5-stage core datapath and the hazard/stall
//               controller.
//               master : datapath side, drives ID/EX/MEM status, receives
//                        stall/flush controls.
//               slave  : pipe_ctrl side.
//               Status : id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read,
//                        ex_rt, ex_muldiv, ex_mem_req, mem_ack, ex_branch_taken
//               Control: pc_write, hazard_stall, exe_stall, cond_exe_stall,
//                        idex_flush, muldiv_busy
//               Optional (PIPE_CTRL_STATS_EN): stall_cycles, flush_count
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_muldiv;
    logic        ex_mem_req;
    logic        mem_ack;
    logic        ex_branch_taken;

    logic        pc_write;
    logic        hazard_stall;
    logic        exe_stall;
    logic        cond_exe_stall;
    logic        idex_flush;
    logic        muldiv_busy;
`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    modport master (
`ifdef PIPE_CTRL_STATS_EN
        input  stall_cycles,
        input  flush_count,
`endif
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_mem_read, ex_rt, ex_muldiv, ex_mem_req, mem_ack,
        output ex_branch_taken,
        input  pc_write, hazard_stall, exe_stall, cond_exe_stall,
        input  idex_flush, muldiv_busy
    );

    modport slave (
`ifdef PIPE_CTRL_STATS_EN
        output stall_cycles,
        output flush_count,
`endif
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_mem_read, ex_rt, ex_muldiv, ex_mem_req, mem_ack,
        input  ex_branch_taken,
        output pc_write, hazard_stall, exe_stall, cond_exe_stall,
        output idex_flush, muldiv_busy
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Hazard and stall controller for the 5-stage MIPS core.
//               Handles load-use interlocks, multi-cycle mult/div occupancy
//               of EX (IDLE/MULDIV/MEMWAIT FSM), data-memory wait and
//               taken-branch flushes.
// Ports       : clk    - core clock, rising edge
//               resetn - synchronous active-low reset
//               bus    - pipe_ctrl_if.slave (status in, stall/flush out)
// Parameters  : MULDIV_CYCLES - total EX occupancy of a mult/div (2..255)
// Options     : PIPE_CTRL_STATS_EN - adds 32-bit stall_cycles / flush_count
//               counters on the interface.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    pipe_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MULDIV  = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    localparam logic [7:0] C_MD_LOAD  = 8'(MULDIV_CYCLES - 2);

    logic [1:0] state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;

    logic       exe_stall_raw;
    logic       load_use;
    logic       branch_qual;
    logic       hazard_raw;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // mult/div wins over a simultaneous memory request; the
                // request is seen again once the FSM is back in IDLE.
                if (bus.ex_muldiv) begin
                    state_d  = ST_MULDIV;
                    md_cnt_d = C_MD_LOAD;
                end else if (bus.ex_mem_req && !bus.mem_ack) begin
                    state_d  = ST_MEMWAIT;
                end
            end
            ST_MULDIV: begin
                // The count is decremented every cycle; the FSM leaves as the
                // count reaches zero, so MULDIV lasts MULDIV_CYCLES-2 stalled
                // cycles (one non-stalled cycle when the load value is 0).
                md_cnt_d = (md_cnt_q == 8'd0) ? 8'd0 : md_cnt_q - 8'd1;
                if (md_cnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEMWAIT: begin
                if (bus.mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                md_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            md_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stall / flush decode (combinational, zero latency)
    // ------------------------------------------------------------------
    always_comb begin
        exe_stall_raw = 1'b0;
        case (state_q)
            ST_IDLE:    exe_stall_raw = bus.ex_muldiv |
                                        (bus.ex_mem_req & ~bus.mem_ack);
            ST_MULDIV:  exe_stall_raw = (md_cnt_q != 8'd0);
            ST_MEMWAIT: exe_stall_raw = ~bus.mem_ack;
            default:    exe_stall_raw = 1'b0;
        endcase
    end

    always_comb begin
        load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                   ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
                    (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));
        // A stalled EX cannot resolve a branch; a flushed ID instruction
        // cannot cause an interlock.
        branch_qual = bus.ex_branch_taken && !exe_stall_raw;
        hazard_raw  = load_use && !exe_stall_raw && !branch_qual;
    end

    // Every output is held low while reset is asserted.
    assign bus.exe_stall      = resetn & exe_stall_raw;
    assign bus.hazard_stall   = resetn & hazard_raw;
    assign bus.cond_exe_stall = resetn & branch_qual;
    assign bus.idex_flush     = resetn & (hazard_raw | branch_qual);
    assign bus.pc_write       = resetn & ~(hazard_raw | exe_stall_raw);
    assign bus.muldiv_busy    = resetn & (state_q == ST_MULDIV);

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q,  flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (resetn && !bus.pc_write) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (bus.cond_exe_stall) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed scoreboard bench for pipe_ctrl with MULDIV_CYCLES=4.
//               Expected vector = {pc_write, hazard_stall, exe_stall,
//               cond_exe_stall, idex_flush, muldiv_busy}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic clk;
    logic resetn;

    pipe_ctrl_if intf ();

    pipe_ctrl #(.MULDIV_CYCLES(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Stimulus: one call = one clock cycle of inputs plus its expectation
    // ------------------------------------------------------------------
    task automatic step(input string name, input logic rn,
                        input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic md, input logic req, input logic ack,
                        input logic br, input logic [5:0] exp);
        @(posedge clk);
        #1;
        resetn               = rn;
        intf.ex_mem_read     = mr;
        intf.ex_rt           = ert;
        intf.id_rs           = rs;
        intf.id_uses_rs      = urs;
        intf.id_rt           = rt;
        intf.id_uses_rt      = urt;
        intf.ex_muldiv       = md;
        intf.ex_mem_req      = req;
        intf.mem_ack         = ack;
        intf.ex_branch_taken = br;
        sb_q.push_back('{name, exp});
    endtask

    task automatic idle(input string name);
        step(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000);
    endtask

`ifdef PIPE_CTRL_STATS_EN
    task automatic check_stats(input string name, input logic [31:0] e_stall,
                               input logic [31:0] e_flush);
        checks++;
        if (intf.stall_cycles !== e_stall || intf.flush_count !== e_flush) begin
            errors++;
            $display("FAIL %s: stall_cycles=%0d flush_count=%0d, required %0d / %0d",
                     name, intf.stall_cycles, intf.flush_count, e_stall, e_flush);
        end
    endtask
`endif

    // ------------------------------------------------------------------
    // Monitor: every cycle the DUT presents a full control vector
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                sb_entry_t e;
                logic [5:0] act;
                e   = sb_q.pop_front();
                act = {intf.pc_write, intf.hazard_stall, intf.exe_stall,
                       intf.cond_exe_stall, intf.idex_flush, intf.muldiv_busy};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: {pc_write,hazard,exe,cond,flush,busy} got %b, required %b",
                             e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // args: name rn mr ert rs urs rt urt md req ack br exp
    // ------------------------------------------------------------------
    initial begin
        resetn = 1'b0;
        intf.ex_mem_read = 0; intf.ex_rt = 0; intf.id_rs = 0; intf.id_uses_rs = 0;
        intf.id_rt = 0; intf.id_uses_rt = 0; intf.ex_muldiv = 0;
        intf.ex_mem_req = 0; intf.mem_ack = 0; intf.ex_branch_taken = 0;

        step("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
        step("reset1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 6'b000000);
        idle("post_reset");

        // load-use on rs, then r0 never interlocks
        step("lu_rs",  1, 1, 8, 8, 1, 0, 0, 0, 0, 0, 0, 6'b010010);
        idle("lu_rs_after");
        step("lu_r0",  1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 6'b100000);

        // mult/div, 3 stall cycles, busy for 2
        step("md_detect", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001000);
        step("md_busy1",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001);
        step("md_busy2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001);
        idle("md_done");

        // memory wait: 5 stalled cycles, released in the ack cycle
        for (int i = 0; i < 5; i++)
            step("mem_wait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001000);
        step("mem_ack",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b100000);
        idle("mem_done");

        // branch beats load-use
        step("br_lu", 1, 1, 8, 8, 1, 0, 0, 0, 0, 0, 1, 6'b100110);
        idle("br_done");
`ifdef PIPE_CTRL_STATS_EN
        check_stats("stats_after_scenarios", 32'd9, 32'd1);
`endif

        // load-use via rt, and a non-used matching rs
        step("lu_rt",     1, 1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 6'b010010);
        step("lu_unused", 1, 1, 8, 8, 0, 3, 1, 0, 0, 0, 0, 6'b100000);

        // ack in the request cycle gives no stall
        step("mem_fast",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b100000);

        // exe_stall suppresses branch and load-use
        step("stall_br",  1, 1, 8, 8, 1, 0, 0, 0, 1, 0, 1, 6'b001000);
        step("stall_ack", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b100000);

        // back-to-back mult/div
        step("b2b_d1", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001000);
        step("b2b_b1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001);
        step("b2b_b2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001);
        step("b2b_d2", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001000);
        step("b2b_b3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001);
        step("b2b_b4", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001);
        idle("b2b_done");

        // mult/div and memory request together: mult/div first
        step("both_d",  1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6'b001000);
        step("both_b1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001001);
        step("both_b2", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001001);
        step("both_mem",1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001000);
        step("both_ack",1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b100000);

        // reset on the 2nd busy cycle aborts the mult/div
        step("rst_md_d",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001000);
        step("rst_md_b1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001);
        step("rst_md_b2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
        idle("rst_md_release");
`ifdef PIPE_CTRL_STATS_EN
        check_stats("stats_after_reset", 32'd0, 32'd0);
`endif
        idle("rst_md_idle");

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
